prog_ram: RTL and testbench

//   Parametrised single-port data/program RAM for the 8-bit CPU core, the successor to the fixed 16x8 RAM.
//   CPU side: synchronous read with 1-cycle latency, plus a write strobe.

---
 rtl/prog_ram.sv | 126 ++++++++++++
 tb/tb_prog_ram.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram.sv
// Single-port data/program RAM for the 8-bit CPU core. The CPU side has a synchronous read
// with a 1-cycle latency and a write strobe. The loader side is a valid/ready streaming
// programmer with an auto-incrementing pointer. An optional sweep zeroes the array after reset.
module prog_ram #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_done,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        StClear,
        StRun,
        StProg
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] prog_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign prog_ready = (state == StProg);
    assign busy       = (state == StClear);
    assign prog_addr  = prog_ptr;
    assign accept     = prog_valid && prog_ready;

    // Select the single write source: clear sweep, loader, or CPU; the loader owns PROG state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = w_data;
        unique case (state)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end
            StProg: begin
                mem_we    = accept;
                mem_waddr = prog_ptr;
                mem_wdata = prog_data;
            end
            StRun: begin
                mem_we    = w_en;
            end
            default: begin
                mem_we    = 1'b0;
            end
        endcase
    end

    // Array storage; reset never touches the contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered read data and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? StClear : StRun;
            clr_ptr   <= '0;
            prog_ptr  <= '0;
            r_data    <= '0;
            prog_done <= 1'b0;
        end else begin
            unique case (state)
                StClear: begin
                    r_data    <= '0;
                    prog_done <= 1'b0;
                    clr_ptr   <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    // Non-blocking read sees the pre-write contents on a same-address write.
                    r_data    <= mem[address];
                    prog_done <= 1'b0;
                    if (prog_mode) begin
                        state    <= StProg;
                        prog_ptr <= '0;
                    end
                end
                StProg: begin
                    r_data    <= mem[address];
                    // Suppress the pulse when leaving, so it never shows outside PROG.
                    prog_done <= accept && (prog_ptr == LAST_ADDR) && prog_mode;
                    if (accept) begin
                        prog_ptr <= prog_ptr + 1'b1;
                    end
                    if (!prog_mode) begin
                        state <= StRun;
                    end
                end
                default: begin
                    state     <= StRun;
                    prog_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ram.sv
// Directed self-checking bench for prog_ram (DATA_W=8, ADDR_W=4, CLEAR_ON_RESET=1).
module tb_prog_ram;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [3:0] address;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic [3:0] prog_addr;
    logic       prog_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    prog_ram #(
        .DATA_W        (8),
        .ADDR_W        (4),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .address   (address),
        .w_data    (w_data),
        .r_data    (r_data),
        .prog_mode (prog_mode),
        .prog_valid(prog_valid),
        .prog_data (prog_data),
        .prog_ready(prog_ready),
        .prog_addr (prog_addr),
        .prog_done (prog_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts negedge samples with busy=1, bounded so a stuck sweep cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || prog_ready !== 1'b0 || prog_done !== 1'b0 ||
            prog_addr !== 4'h0 || r_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ready=%b done=%b paddr=%h rdata=%h, want 1 0 0 0 00",
                     busy, prog_ready, prog_done, prog_addr, r_data);
        end
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_length: busy cycles=%0d, want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            @(negedge clk);
            checks++;
            if (r_data !== 8'h00) begin
                errors++;
                $display("FAIL clear_readback[%0d]: r_data=%h, want 00", i, r_data);
            end
        end
    endtask

    task automatic test_write_read;
        address = 4'h3;
        w_data  = 8'hA5;
        w_en    = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        checks++;
        if (r_data !== 8'h00) begin
            errors++;
            $display("FAIL rdw_first: r_data=%h, want 00", r_data);
        end
        @(negedge clk);
        checks++;
        if (r_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_read: r_data=%h, want a5", r_data);
        end
        w_data = 8'h5A;
        w_en   = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        checks++;
        if (r_data !== 8'hA5) begin
            errors++;
            $display("FAIL rdw_old: r_data=%h, want a5", r_data);
        end
        @(negedge clk);
        checks++;
        if (r_data !== 8'h5A) begin
            errors++;
            $display("FAIL rdw_new: r_data=%h, want 5a", r_data);
        end
    endtask

    task automatic test_prog_stream;
        int pulses = 0;
        prog_mode = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_ready !== 1'b1 || prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL prog_enter: ready=%b paddr=%h, want 1 0", prog_ready, prog_addr);
        end
        prog_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_data = 8'h10 + 8'(i);
            checks++;
            if (prog_addr !== 4'(i)) begin
                errors++;
                $display("FAIL stream_addr[%0d]: prog_addr=%h, want %h", i, prog_addr, 4'(i));
            end
            @(negedge clk);
            if (prog_done === 1'b1) pulses++;
            checks++;
            if (prog_done !== (i == 15)) begin
                errors++;
                $display("FAIL stream_done[%0d]: prog_done=%b, want %b", i, prog_done, (i == 15));
            end
        end
        checks++;
        if (prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL stream_wrap: prog_addr=%h, want 0", prog_addr);
        end
        prog_valid = 1'b0;
        @(negedge clk);
        if (prog_done === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL done_pulses: count=%0d, want 1", pulses);
        end
        prog_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (prog_ready !== 1'b0) begin
            errors++;
            $display("FAIL prog_exit: prog_ready=%b, want 0", prog_ready);
        end
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            @(negedge clk);
            checks++;
            if (r_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL stream_readback[%0d]: r_data=%h, want %h", i, r_data, 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_prog_toggle;
        logic [7:0] exp [5];
        exp[0] = 8'hC0;
        exp[1] = 8'hC1;
        exp[2] = 8'hC2;
        exp[3] = 8'hC3;
        exp[4] = 8'h14;
        prog_mode = 1'b1;
        @(negedge clk);
        w_en    = 1'b1;
        address = 4'h0;
        w_data  = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            prog_valid = (c % 2 == 0);
            prog_data  = (c % 2 == 0) ? 8'hC0 + 8'(c / 2) : 8'hEE;
            @(negedge clk);
        end
        checks++;
        if (prog_addr !== 4'h4) begin
            errors++;
            $display("FAIL toggle_addr: prog_addr=%h, want 4", prog_addr);
        end
        prog_valid = 1'b0;
        w_en       = 1'b0;
        prog_mode  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            address = 4'(i);
            @(negedge clk);
            checks++;
            if (r_data !== exp[i]) begin
                errors++;
                $display("FAIL toggle_readback[%0d]: r_data=%h, want %h", i, r_data, exp[i]);
            end
        end
    endtask

    task automatic test_prog_exit;
        prog_mode = 1'b1;
        @(negedge clk);
        prog_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            prog_data = 8'h30 + 8'(i);
            @(negedge clk);
        end
        checks++;
        if (prog_addr !== 4'h5) begin
            errors++;
            $display("FAIL exit_addr: prog_addr=%h, want 5", prog_addr);
        end
        prog_data = 8'h35;
        prog_mode = 1'b0;
        @(negedge clk);
        prog_valid = 1'b0;
        checks++;
        if (prog_ready !== 1'b0 || prog_addr !== 4'h6) begin
            errors++;
            $display("FAIL exit_state: ready=%b paddr=%h, want 0 6", prog_ready, prog_addr);
        end
        address = 4'h5;
        @(negedge clk);
        checks++;
        if (r_data !== 8'h35) begin
            errors++;
            $display("FAIL exit_word: r_data=%h, want 35", r_data);
        end
        prog_mode = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_ready !== 1'b1 || prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL reenter: ready=%b paddr=%h, want 1 0", prog_ready, prog_addr);
        end
        prog_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        address = 4'h8;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || r_data !== 8'h00 || prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%b rdata=%h paddr=%h, want 1 00 0",
                     busy, r_data, prog_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reclear_length: busy cycles=%0d, want 16", n);
        end
        address = 4'hF;
        @(negedge clk);
        checks++;
        if (r_data !== 8'h00) begin
            errors++;
            $display("FAIL reclear_word15: r_data=%h, want 00", r_data);
        end
        address   = 4'h2;
        prog_mode = 1'b1;
        @(negedge clk);
        prog_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            prog_data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        checks++;
        if (prog_addr !== 4'h9 || prog_ready !== 1'b1 || r_data !== 8'h42) begin
            errors++;
            $display("FAIL pre_reset_prog: paddr=%h ready=%b rdata=%h, want 9 1 42",
                     prog_addr, prog_ready, r_data);
        end
        #2;
        rst        = 1'b1;
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        #1;
        checks++;
        if (prog_addr !== 4'h0 || prog_ready !== 1'b0 || busy !== 1'b1 ||
            r_data !== 8'h00 || prog_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_prog: paddr=%h ready=%b busy=%b rdata=%h done=%b, want 0 0 1 00 0",
                     prog_addr, prog_ready, busy, r_data, prog_done);
        end
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reclear2_length: busy cycles=%0d, want 16", n);
        end
    endtask

    initial begin
        rst        = 1'b1;
        w_en       = 1'b0;
        address    = 4'h0;
        w_data     = 8'h00;
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        prog_data  = 8'h00;
        test_reset();
        test_write_read();
        test_prog_stream();
        test_prog_toggle();
        test_prog_exit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
